// File: rtl/vscale_dmem_bridge_pkg.sv
// Shared types and constants for the vscale data-memory bridge.
package vscale_dmem_bridge_pkg;

  localparam int unsigned DmemStrbW          = 4;
  localparam int unsigned DmemTimeoutDefault = 255;

  // Pipeline access-size codes; LB/LH/LW reuse the SB/SH/SW codes with wen=0.
  localparam logic [2:0] MemTypeSb  = 3'd0;
  localparam logic [2:0] MemTypeSh  = 3'd1;
  localparam logic [2:0] MemTypeSw  = 3'd2;
  localparam logic [2:0] MemTypeLbu = 3'd4;
  localparam logic [2:0] MemTypeLhu = 3'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2,
    StErr  = 2'd3
  } dmem_state_e;

endpackage

// File: rtl/vscale_dmem_strb_gen.sv
// Byte-enable and misalignment decode for one data-memory access.
module vscale_dmem_strb_gen
  import vscale_dmem_bridge_pkg::*;
(
  input  logic                 wen,
  input  logic [2:0]           size,
  input  logic [1:0]           addr_lo,
  output logic [DmemStrbW-1:0] strb,
  output logic                 misaligned
);

  // Decode lanes from size/offset; loads never assert byte enables.
  always_comb begin
    strb       = '0;
    misaligned = 1'b0;
    case (size)
      MemTypeSb, MemTypeLbu: strb = 4'b0001 << addr_lo;
      MemTypeSh, MemTypeLhu: begin
        strb       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      MemTypeSw: begin
        strb       = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
    if (!wen) begin
      strb = '0;
    end
  end

endmodule

// File: rtl/vscale_dmem_bridge.sv
// Bridge from the vscale split-phase dmem port to a valid/ready bus.
// One outstanding access. Optional response timeout via VSCALE_DMEM_TIMEOUT_EN.
module vscale_dmem_bridge
  import vscale_dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DmemTimeoutDefault,
  parameter int unsigned TIMEOUT_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dmem_en,
  input  logic                 dmem_wen,
  input  logic [2:0]           dmem_size,
  input  logic [31:0]          dmem_addr,
  input  logic [31:0]          dmem_wdata_delayed,
  output logic [31:0]          dmem_rdata,
  output logic                 dmem_wait,
  output logic                 dmem_badmem_e,
  output logic                 bus_req_valid,
  input  logic                 bus_req_ready,
  output logic                 bus_req_write,
  output logic [31:0]          bus_req_addr,
  output logic [31:0]          bus_req_wdata,
  output logic [DmemStrbW-1:0] bus_req_wstrb,
  input  logic                 bus_resp_valid,
  input  logic [31:0]          bus_resp_rdata,
  input  logic                 bus_resp_err
);

  if (TIMEOUT_CYCLES == 0 || 64'(TIMEOUT_CYCLES) >= (64'd1 << TIMEOUT_CNT_W)) begin : g_bad_cfg
    $error("TIMEOUT_CNT_W cannot hold TIMEOUT_CYCLES");
  end

  dmem_state_e          state_q, state_d;
  logic [29:0]          word_addr_q;
  logic                 wen_q;
  logic [DmemStrbW-1:0] strb_q;

  logic [DmemStrbW-1:0] strb_in;
  logic                 misaligned_in;
  logic                 accept;
  logic                 resp_hit;
  logic                 timeout;
  logic                 complete;

  vscale_dmem_strb_gen u_strb_gen (
    .wen        (dmem_wen),
    .size       (dmem_size),
    .addr_lo    (dmem_addr[1:0]),
    .strb       (strb_in),
    .misaligned (misaligned_in)
  );

  assign accept   = dmem_en & ~dmem_wait;
  assign complete = (state_q == StResp) & (resp_hit | timeout);

`ifdef VSCALE_DMEM_TIMEOUT_EN
  logic [TIMEOUT_CNT_W-1:0] cnt_q, cnt_d;
  logic                     orphan_q, orphan_d;

  // A response owed to a timed-out access must not complete a later one.
  assign resp_hit = bus_resp_valid & ~orphan_q;
  assign timeout  = (state_q == StResp) & ~resp_hit &
                    (cnt_q == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));

  // Response-wait counter and orphan-response tracking.
  always_comb begin
    cnt_d    = cnt_q;
    orphan_d = orphan_q;
    if (state_q == StReq && bus_req_ready) begin
      cnt_d = '0;
    end else if (state_q == StResp && !complete) begin
      cnt_d = cnt_q + TIMEOUT_CNT_W'(1);
    end
    if (timeout) begin
      orphan_d = 1'b1;
    end else if (orphan_q && bus_resp_valid) begin
      orphan_d = 1'b0;
    end
  end

  // Timeout state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      orphan_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
    end
  end
`else
  assign resp_hit = bus_resp_valid;
  assign timeout  = 1'b0;
`endif

  // Next state: an accept (only possible while not stalled) overrides the per-state move.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StErr: state_d = StIdle;
      StReq:         if (bus_req_ready) state_d = StResp;
      StResp:        if (complete) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
    if (accept) begin
      state_d = misaligned_in ? StErr : StReq;
    end
  end

  // State and captured address-phase fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      word_addr_q <= '0;
      wen_q       <= 1'b0;
      strb_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_addr_q <= dmem_addr[31:2];
        wen_q       <= dmem_wen;
        strb_q      <= strb_in;
      end
    end
  end

  // Pipeline- and bus-facing outputs, decoded from the current state.
  always_comb begin
    dmem_rdata    = '0;
    dmem_wait     = 1'b0;
    dmem_badmem_e = 1'b0;
    bus_req_valid = 1'b0;
    bus_req_write = 1'b0;
    bus_req_addr  = '0;
    bus_req_wdata = '0;
    bus_req_wstrb = '0;
    unique case (state_q)
      StIdle: ;
      StReq: begin
        bus_req_valid = 1'b1;
        bus_req_write = wen_q;
        bus_req_addr  = {word_addr_q, 2'b00};
        bus_req_wdata = dmem_wdata_delayed;
        bus_req_wstrb = strb_q;
        dmem_wait     = 1'b1;
      end
      StResp: begin
        dmem_wait = ~(resp_hit | timeout);
        if (resp_hit) begin
          dmem_rdata    = bus_resp_rdata;
          dmem_badmem_e = bus_resp_err;
        end else if (timeout) begin
          dmem_badmem_e = 1'b1;
        end
      end
      StErr:   dmem_badmem_e = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Self-checking bench for vscale_dmem_bridge (build with VSCALE_DMEM_TIMEOUT_EN for timeout cases).
module tb_vscale_dmem_bridge;

`ifdef VSCALE_DMEM_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        dmem_en, dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr, dmem_wdata_delayed, dmem_rdata;
  logic        dmem_wait, dmem_badmem_e;
  logic        bus_req_valid, bus_req_ready, bus_req_write;
  logic [31:0] bus_req_addr, bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_resp_valid, bus_resp_err;
  logic [31:0] bus_resp_rdata;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  vscale_dmem_bridge #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_CNT_W  (8)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .dmem_en            (dmem_en),
    .dmem_wen           (dmem_wen),
    .dmem_size          (dmem_size),
    .dmem_addr          (dmem_addr),
    .dmem_wdata_delayed (dmem_wdata_delayed),
    .dmem_rdata         (dmem_rdata),
    .dmem_wait          (dmem_wait),
    .dmem_badmem_e      (dmem_badmem_e),
    .bus_req_valid      (bus_req_valid),
    .bus_req_ready      (bus_req_ready),
    .bus_req_write      (bus_req_write),
    .bus_req_addr       (bus_req_addr),
    .bus_req_wdata      (bus_req_wdata),
    .bus_req_wstrb      (bus_req_wstrb),
    .bus_resp_valid     (bus_resp_valid),
    .bus_resp_rdata     (bus_resp_rdata),
    .bus_resp_err       (bus_resp_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int size_bytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Transaction-level model: obligations the bridge owes the pipeline and the bus.
  bit          m_fault;        // misaligned access accepted last cycle -> fault now
  bit          m_req_pending;  // accepted request not yet handshaken on the bus
  bit          m_await;        // handshaken request whose response is still owed
  bit          m_orphan;       // response of a timed-out request still to arrive
  int          m_wait_cycles;
  logic [31:0] m_addr;
  logic        m_write;
  logic [3:0]  m_strb;

  initial begin
    m_fault = 0; m_req_pending = 0; m_await = 0; m_orphan = 0; m_wait_cycles = 0;
    m_addr = '0; m_write = 0; m_strb = '0;
  end

  always @(negedge clk) begin : model_cmp
    bit          resp_ok, timed_out, exp_wait, exp_bad, acc, mis;
    logic [31:0] exp_rdata;
    int          nb;
    resp_ok   = m_await && bus_resp_valid && !m_orphan;
    timed_out = 1'b0;
`ifdef VSCALE_DMEM_TIMEOUT_EN
    timed_out = m_await && !resp_ok && (m_wait_cycles == int'(TO) - 1);
`endif
    exp_wait  = m_req_pending || (m_await && !resp_ok && !timed_out);
    exp_bad   = m_fault || (resp_ok && bus_resp_err) || timed_out;
    exp_rdata = resp_ok ? bus_resp_rdata : 32'h0;
    if (cmp_on) begin
      chk("model_wait", {31'b0, dmem_wait}, {31'b0, exp_wait});
      chk("model_badmem", {31'b0, dmem_badmem_e}, {31'b0, exp_bad});
      chk("model_rdata", dmem_rdata, exp_rdata);
      chk("model_req_valid", {31'b0, bus_req_valid}, {31'b0, m_req_pending});
      if (m_req_pending) begin
        chk("model_req_addr", bus_req_addr, m_addr);
        chk("model_req_write", {31'b0, bus_req_write}, {31'b0, m_write});
        chk("model_req_wstrb", {28'b0, bus_req_wstrb}, {28'b0, m_strb});
        chk("model_req_wdata", bus_req_wdata, dmem_wdata_delayed);
      end
    end
    if (reset) begin
      m_fault = 0; m_req_pending = 0; m_await = 0; m_orphan = 0; m_wait_cycles = 0;
    end else begin
      acc = dmem_en && !exp_wait;
      nb  = size_bytes(dmem_size);
      mis = (nb > 1) && ((dmem_addr % nb) != 0);
      if (resp_ok || timed_out) m_await = 0;
      else if (m_await) m_wait_cycles++;
      if (timed_out) m_orphan = 1;
      else if (m_orphan && bus_resp_valid) m_orphan = 0;
      if (m_req_pending && bus_req_ready) begin
        m_req_pending = 0;
        m_await       = 1;
        m_wait_cycles = 0;
      end
      m_fault = acc && mis;
      if (acc && !mis) begin
        m_req_pending = 1;
        m_addr        = dmem_addr - (dmem_addr % 4);
        m_write       = dmem_wen;
        m_strb        = dmem_wen ? 4'(((1 << nb) - 1) << (dmem_addr % 4)) : 4'h0;
      end
    end
  end

  // One complete access with a bench-driven bus; literal expectations passed in.
  task automatic run_access(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ready_lat, input int resp_lat,
                            input logic [31:0] rdata, input logic err,
                            input logic [3:0] exp_strb, input logic exp_fault);
    dmem_en = 1; dmem_wen = wen; dmem_size = size; dmem_addr = addr; bus_req_ready = 0;
    @(negedge clk);
    chk("accept_wait", {31'b0, dmem_wait}, 32'd0);
    step();
    dmem_en = 0; dmem_wdata_delayed = wdata;
    if (exp_fault) begin
      @(negedge clk);
      chk("fault_req_valid", {31'b0, bus_req_valid}, 32'd0);
      chk("fault_badmem", {31'b0, dmem_badmem_e}, 32'd1);
      chk("fault_wait", {31'b0, dmem_wait}, 32'd0);
      chk("fault_rdata", dmem_rdata, 32'd0);
      step();
      return;
    end
    for (int i = 0; i < ready_lat; i++) begin
      @(negedge clk);
      chk("req_held_valid", {31'b0, bus_req_valid}, 32'd1);
      chk("req_held_wait", {31'b0, dmem_wait}, 32'd1);
      step();
    end
    bus_req_ready = 1;
    @(negedge clk);
    chk("req_wstrb", {28'b0, bus_req_wstrb}, {28'b0, exp_strb});
    chk("req_addr", bus_req_addr, {addr[31:2], 2'b00});
    chk("req_wait", {31'b0, dmem_wait}, 32'd1);
    step();
    bus_req_ready = 0;
    for (int i = 1; i < resp_lat; i++) begin
      @(negedge clk);
      chk("resp_pending_wait", {31'b0, dmem_wait}, 32'd1);
      step();
    end
    bus_resp_valid = 1; bus_resp_rdata = rdata; bus_resp_err = err;
    @(negedge clk);
    chk("done_wait", {31'b0, dmem_wait}, 32'd0);
    chk("done_rdata", dmem_rdata, rdata);
    chk("done_badmem", {31'b0, dmem_badmem_e}, {31'b0, err});
    step();
    bus_resp_valid = 0; bus_resp_rdata = '0; bus_resp_err = 0;
  endtask

  typedef struct {
    logic       wen;
    logic [2:0] size;
    logic [7:0] addr;
    logic [3:0] strb;
    logic       fault;
  } vec_t;

  vec_t vecs[11] = '{
    '{1'b1, 3'd0, 8'h10, 4'b0001, 1'b0},
    '{1'b1, 3'd0, 8'h13, 4'b1000, 1'b0},
    '{1'b1, 3'd1, 8'h20, 4'b0011, 1'b0},
    '{1'b1, 3'd1, 8'h22, 4'b1100, 1'b0},
    '{1'b1, 3'd1, 8'h23, 4'b0000, 1'b1},
    '{1'b1, 3'd2, 8'h24, 4'b1111, 1'b0},
    '{1'b1, 3'd2, 8'h26, 4'b0000, 1'b1},
    '{1'b0, 3'd5, 8'h31, 4'b0000, 1'b1},
    '{1'b0, 3'd5, 8'h32, 4'b0000, 1'b0},
    '{1'b0, 3'd0, 8'h37, 4'b0000, 1'b0},
    '{1'b0, 3'd2, 8'h3c, 4'b0000, 1'b0}
  };

  initial begin
    reset = 1; dmem_en = 0; dmem_wen = 0; dmem_size = '0; dmem_addr = '0;
    dmem_wdata_delayed = '0; bus_req_ready = 0; bus_resp_valid = 0;
    bus_resp_rdata = '0; bus_resp_err = 0;
    step();
    cmp_on = 1;
    step();
    @(negedge clk);
    chk("reset_wait", {31'b0, dmem_wait}, 32'd0);
    chk("reset_badmem", {31'b0, dmem_badmem_e}, 32'd0);
    chk("reset_rdata", dmem_rdata, 32'd0);
    chk("reset_req_valid", {31'b0, bus_req_valid}, 32'd0);
    chk("reset_req_addr", bus_req_addr, 32'd0);
    step();
    reset = 0;

    // SW 0x100, granted at once, response next cycle.
    run_access(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0, 1'b0, 4'b1111, 1'b0);
    // LBU 0x203, ready held low three cycles, response two cycles after handshake.
    run_access(1'b0, 3'd4, 32'h203, 32'h0, 3, 2, 32'h11223344, 1'b0, 4'b0000, 1'b0);

    // Misaligned LH 0x1001 faults; SB 0x1001 accepted in the fault cycle.
    dmem_en = 1; dmem_wen = 0; dmem_size = 3'd1; dmem_addr = 32'h1001;
    step();
    dmem_en = 1; dmem_wen = 1; dmem_size = 3'd0; dmem_addr = 32'h1001;
    @(negedge clk);
    chk("lh_fault_req_valid", {31'b0, bus_req_valid}, 32'd0);
    chk("lh_fault_wait", {31'b0, dmem_wait}, 32'd0);
    chk("lh_fault_badmem", {31'b0, dmem_badmem_e}, 32'd1);
    chk("lh_fault_rdata", dmem_rdata, 32'd0);
    step();
    dmem_en = 0; dmem_wdata_delayed = 32'h5A5A5A5A; bus_req_ready = 1;
    @(negedge clk);
    chk("sb_req_wstrb", {28'b0, bus_req_wstrb}, 32'b0010);
    chk("sb_req_addr", bus_req_addr, 32'h1000);
    chk("sb_req_wdata", bus_req_wdata, 32'h5A5A5A5A);
    step();
    bus_req_ready = 0; bus_resp_valid = 1;
    @(negedge clk);
    chk("sb_done_wait", {31'b0, dmem_wait}, 32'd0);
    step();
    bus_resp_valid = 0;

    // Load with bus error; SH 0x2 accepted back-to-back in the completion cycle.
    dmem_en = 1; dmem_wen = 0; dmem_size = 3'd2; dmem_addr = 32'h300; bus_req_ready = 1;
    step();
    dmem_en = 0;
    step();
    bus_req_ready = 0; bus_resp_valid = 1; bus_resp_err = 1; bus_resp_rdata = 32'hCAFEF00D;
    dmem_en = 1; dmem_wen = 1; dmem_size = 3'd1; dmem_addr = 32'h2;
    @(negedge clk);
    chk("err_badmem", {31'b0, dmem_badmem_e}, 32'd1);
    chk("err_wait", {31'b0, dmem_wait}, 32'd0);
    chk("err_rdata", dmem_rdata, 32'hCAFEF00D);
    step();
    dmem_en = 0; bus_resp_valid = 0; bus_resp_err = 0; bus_resp_rdata = '0;
    dmem_wdata_delayed = 32'hBEEFBEEF; bus_req_ready = 1;
    @(negedge clk);
    chk("b2b_req_valid", {31'b0, bus_req_valid}, 32'd1);
    chk("b2b_req_wstrb", {28'b0, bus_req_wstrb}, 32'b1100);
    chk("b2b_req_addr", bus_req_addr, 32'h0);
    step();
    bus_req_ready = 0; bus_resp_valid = 1;
    step();
    bus_resp_valid = 0;

    // Reset while a request sits unaccepted on the bus.
    dmem_en = 1; dmem_wen = 0; dmem_size = 3'd2; dmem_addr = 32'h400; bus_req_ready = 0;
    step();
    dmem_en = 0; reset = 1;
    @(negedge clk);
    chk("pre_reset_req_valid", {31'b0, bus_req_valid}, 32'd1);
    step();
    reset = 0;
    @(negedge clk);
    chk("post_reset_req_valid", {31'b0, bus_req_valid}, 32'd0);
    chk("post_reset_wait", {31'b0, dmem_wait}, 32'd0);
    step();

`ifdef VSCALE_DMEM_TIMEOUT_EN
    // Timeout on the 4th response cycle; the late response lands on the next access.
    dmem_en = 1; dmem_wen = 0; dmem_size = 3'd2; dmem_addr = 32'h500; bus_req_ready = 1;
    step();
    dmem_en = 0;
    step();
    bus_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_waiting", {31'b0, dmem_wait}, 32'd1);
      step();
    end
    dmem_en = 1; dmem_wen = 0; dmem_size = 3'd2; dmem_addr = 32'h600;
    @(negedge clk);
    chk("to_fire_wait", {31'b0, dmem_wait}, 32'd0);
    chk("to_fire_badmem", {31'b0, dmem_badmem_e}, 32'd1);
    chk("to_fire_rdata", dmem_rdata, 32'd0);
    step();
    dmem_en = 0; bus_req_ready = 1;
    step();
    bus_req_ready = 0; bus_resp_valid = 1; bus_resp_rdata = 32'hBADBAD00;
    @(negedge clk);
    chk("orphan_wait", {31'b0, dmem_wait}, 32'd1);
    chk("orphan_rdata", dmem_rdata, 32'd0);
    step();
    bus_resp_rdata = 32'h0000600D;
    @(negedge clk);
    chk("after_orphan_wait", {31'b0, dmem_wait}, 32'd0);
    chk("after_orphan_rdata", dmem_rdata, 32'h0000600D);
    chk("after_orphan_badmem", {31'b0, dmem_badmem_e}, 32'd0);
    step();
    bus_resp_valid = 0; bus_resp_rdata = '0;
`endif

    foreach (vecs[i]) begin
      run_access(vecs[i].wen, vecs[i].size, {24'h0, vecs[i].addr}, 32'hA5000000 + i,
                 i % 2, 1 + int'(i % 3 == 0), 32'h10000000 + i, 1'b0,
                 vecs[i].strb, vecs[i].fault);
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
